// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues req/ack memory fetches, delivers words to decode over valid/ready.
// Redirects (start/branch) flush in-flight fetches; stop returns to IDLE at the next acceptance.
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  start_address_i,
    input  logic               branch_i,
    input  logic [ADDR_W-1:0]  branchloc_i,
    input  logic               stop_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_data_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DELIVER,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   last_pc_q, last_pc_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                stop_pend_q, stop_pend_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;

    logic                redir;
    logic [ADDR_W-1:0]   redir_addr;
    logic                accept;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        last_pc_d   = last_pc_q;
        target_d    = target_q;
        stop_pend_d = stop_pend_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;

        redir      = start_i | (branch_i & (state_q != S_IDLE));
        redir_addr = start_i ? start_address_i : last_pc_q + branchloc_i;
        accept     = (state_q == S_DELIVER) & instr_ready_i;

        // Branch target uses last_pc before this cycle's acceptance update.
        if (start_i) begin
            last_pc_d   = start_address_i;
            stop_pend_d = 1'b0;
        end else if (accept) begin
            last_pc_d = instr_pc_q;
        end

        if (redir) begin
            target_d = redir_addr;
        end else if (stop_i && (state_q != S_IDLE)) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (redir) begin
                    pc_d    = redir_addr;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack_i) begin
                    if (redir) begin
                        pc_d    = redir_addr;
                        state_d = S_FETCH;
                    end else begin
                        instr_d    = mem_data_i;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 1'b1;
                        state_d    = S_DELIVER;
                    end
                end else if (redir) begin
                    // Request must stay stable until acked; pc holds the outstanding address.
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (mem_ack_i) begin
                    pc_d    = redir ? redir_addr : target_q;
                    state_d = S_FETCH;
                end
            end
            S_DELIVER: begin
                if (redir) begin
                    pc_d    = redir_addr;
                    state_d = S_FETCH;
                end else if (accept) begin
                    if (stop_pend_q) begin
                        stop_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            last_pc_q   <= '0;
            target_q    <= '0;
            stop_pend_q <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            last_pc_q   <= last_pc_d;
            target_q    <= target_d;
            stop_pend_q <= stop_pend_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    assign mem_req_o     = (state_q == S_FETCH) | (state_q == S_FLUSH);
    assign mem_addr_o    = pc_q;
    assign instr_valid_o = (state_q == S_DELIVER);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer; memory ack and decode ready are scripted per cycle.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  start_address_i = '0;
    logic        branch_i = 1'b0;
    logic [7:0]  branchloc_i = '0;
    logic        stop_i = 1'b0;
    logic        mem_req_o;
    logic [7:0]  mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [15:0] mem_data_i = '0;
    logic        instr_valid_o;
    logic [15:0] instr_o;
    logic [7:0]  instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .start_address_i (start_address_i),
        .branch_i        (branch_i),
        .branchloc_i     (branchloc_i),
        .stop_i          (stop_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start;
        logic [7:0]  saddr;
        logic        br;
        logic [7:0]  bloc;
        logic        stop, ack;
        logic [15:0] data;
        logic        rdy;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_vld;
        logic [15:0] e_instr;
        logic [7:0]  e_ipc;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic start, input logic [7:0] saddr,
                       input logic br, input logic [7:0] bloc, input logic stop,
                       input logic ack, input logic [15:0] data, input logic rdy,
                       input logic e_req, input logic [7:0] e_addr, input logic e_vld,
                       input logic [15:0] e_instr, input logic [7:0] e_ipc, input logic e_busy);
        vec_t v;
        v.rst = rst; v.start = start; v.saddr = saddr; v.br = br; v.bloc = bloc;
        v.stop = stop; v.ack = ack; v.data = data; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input int step, input logic req, input logic [7:0] addr, input logic vld,
                             input logic [15:0] ins, input logic [7:0] ipc, input logic bsy);
        check("mem_req",     step, {15'd0, mem_req_o},     {15'd0, req});
        check("mem_addr",    step, {8'd0, mem_addr_o},     {8'd0, addr});
        check("instr_valid", step, {15'd0, instr_valid_o}, {15'd0, vld});
        check("instr",       step, instr_o,                ins);
        check("instr_pc",    step, {8'd0, instr_pc_o},     {8'd0, ipc});
        check("busy",        step, {15'd0, busy_o},        {15'd0, bsy});
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_i = v.rst; start_i = v.start; start_address_i = v.saddr;
        branch_i = v.br; branchloc_i = v.bloc; stop_i = v.stop;
        mem_ack_i = v.ack; mem_data_i = v.data; instr_ready_i = v.rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //   rst st saddr br bloc  sp ak data      rd | req addr  vld instr     ipc   busy
        // sequential fetch from 0x10
        row(0, 1, 8'h10, 0, 8'h00, 0, 0, 16'h0000, 0,   1, 8'h10, 0, 16'h0000, 8'h00, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h1010, 0,   0, 8'h11, 1, 16'h1010, 8'h10, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h11, 0, 16'h1010, 8'h10, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h1011, 0,   0, 8'h12, 1, 16'h1011, 8'h11, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h12, 0, 16'h1011, 8'h11, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h1012, 0,   0, 8'h13, 1, 16'h1012, 8'h12, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h13, 0, 16'h1012, 8'h12, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h1013, 0,   0, 8'h14, 1, 16'h1013, 8'h13, 1);
        // backpressure: 5 cycles not ready
        for (int i = 0; i < 5; i++)
            row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 8'h14, 1, 16'h1013, 8'h13, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h14, 0, 16'h1013, 8'h13, 1);
        // start 0x20 while 0x14 is in flight -> flush, then fetch 0x20
        row(0, 1, 8'h20, 0, 8'h00, 0, 0, 16'h0000, 0,   1, 8'h14, 0, 16'h1013, 8'h13, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'hDEAD, 0,   1, 8'h20, 0, 16'h1013, 8'h13, 1);
        // branch -4 from last_pc 0x20 with ack delayed 3 cycles
        row(0, 0, 8'h00, 1, 8'hFC, 0, 0, 16'h0000, 0,   1, 8'h20, 0, 16'h1013, 8'h13, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 0,   1, 8'h20, 0, 16'h1013, 8'h13, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 0,   1, 8'h20, 0, 16'h1013, 8'h13, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'hBEEF, 0,   1, 8'h1C, 0, 16'h1013, 8'h13, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h111C, 0,   0, 8'h1D, 1, 16'h111C, 8'h1C, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h1D, 0, 16'h111C, 8'h1C, 1);
        // wrap: start 0xFE, FF -> 00
        row(0, 1, 8'hFE, 0, 8'h00, 0, 0, 16'h0000, 0,   1, 8'h1D, 0, 16'h111C, 8'h1C, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h0000, 0,   1, 8'hFE, 0, 16'h111C, 8'h1C, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h00FE, 0,   0, 8'hFF, 1, 16'h00FE, 8'hFE, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'hFF, 0, 16'h00FE, 8'hFE, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h00FF, 0,   0, 8'h00, 1, 16'h00FF, 8'hFF, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h00, 0, 16'h00FF, 8'hFF, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h0100, 0,   0, 8'h01, 1, 16'h0100, 8'h00, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h01, 0, 16'h0100, 8'h00, 1);
        // branch +0x80 from last_pc 0x00
        row(0, 0, 8'h00, 1, 8'h80, 0, 0, 16'h0000, 0,   1, 8'h01, 0, 16'h0100, 8'h00, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'hAAAA, 0,   1, 8'h80, 0, 16'h0100, 8'h00, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h0180, 0,   0, 8'h81, 1, 16'h0180, 8'h80, 1);
        // stop in FETCH: deliver, then IDLE after acceptance
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h81, 0, 16'h0180, 8'h80, 1);
        row(0, 0, 8'h00, 0, 8'h00, 1, 0, 16'h0000, 0,   1, 8'h81, 0, 16'h0180, 8'h80, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h0181, 0,   0, 8'h82, 1, 16'h0181, 8'h81, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   0, 8'h82, 0, 16'h0181, 8'h81, 0);
        // start and branch together: start wins (branch would give 0x45)
        row(0, 1, 8'h40, 0, 8'h00, 0, 0, 16'h0000, 0,   1, 8'h40, 0, 16'h0181, 8'h81, 1);
        row(0, 1, 8'h50, 1, 8'h05, 0, 0, 16'h0000, 0,   1, 8'h40, 0, 16'h0181, 8'h81, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h5555, 0,   1, 8'h50, 0, 16'h0181, 8'h81, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'h0150, 0,   0, 8'h51, 1, 16'h0150, 8'h50, 1);
        row(0, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 1,   1, 8'h51, 0, 16'h0150, 8'h50, 1);
        // reset mid-FETCH, then a late ack is ignored
        row(1, 0, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 0,   0, 8'h00, 0, 16'h0000, 8'h00, 0);
        row(0, 0, 8'h00, 0, 8'h00, 0, 1, 16'hFFFF, 0,   0, 8'h00, 0, 16'h0000, 8'h00, 0);

        // reset state
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 0, 8'h00, 0, 16'h0000, 8'h00, 0);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                      vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_busy);
        end

        // Branch in DELIVER with same-cycle acceptance: held word discarded,
        // target uses last_pc from the start (0x30), not the accepted PC.
        v = '{default: '0};
        v.start = 1'b1; v.saddr = 8'h30;
        drive(v);
        check_all(100, 1, 8'h30, 0, 16'h0000, 8'h00, 1);
        v = '{default: '0};
        v.ack = 1'b1; v.data = 16'h0130;
        drive(v);
        check_all(101, 0, 8'h31, 1, 16'h0130, 8'h30, 1);
        v = '{default: '0};
        v.br = 1'b1; v.bloc = 8'h02; v.rdy = 1'b1;
        drive(v);
        check_all(102, 1, 8'h32, 0, 16'h0130, 8'h30, 1);
        v = '{default: '0};
        v.ack = 1'b1; v.data = 16'h0132;
        drive(v);
        check_all(103, 0, 8'h33, 1, 16'h0132, 8'h32, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencing controller for the instruction-fetch path: owns the 8-bit program counter and drives an instruction-memory request/acknowledge port. It delivers fetched instructions to decode over a valid/ready handshake. It applies start, relative-branch and stop redirects, and flushes wrong-path fetches that are still in flight. It sits between the core's start/branch control and the instruction memory, and replaces free-running PC update with a stall-aware, handshake-driven sequence.

## Interface
- ADDR_W, 8, PC and memory address width
- INSTR_W, 16, instruction word width
- clk  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  begin or redirect fetching at start_address_i
- start_address_i  in  ADDR_W  start target
- branch_i  in  1  relative branch redirect
- branchloc_i  in  ADDR_W  branch offset, two's complement
- stop_i  in  1  request return to IDLE
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_W  request address; held stable while mem_req_o=1
- mem_ack_i  in  1  one-cycle acknowledge; mem_data_i is valid in the same cycle
- mem_data_i  in  INSTR_W  fetched word
- instr_valid_o  out  1  instruction available to decode
- instr_o  out  INSTR_W  held instruction
- instr_pc_o  out  ADDR_W  address of instr_o
- instr_ready_i  in  1  decode accepts; an acceptance is instr_valid_o & instr_ready_i
- busy_o  out  1  high in every state except IDLE

## Operation
- Internal registers:
  - pc: next fetch address.
  - last_pc: PC of the most recently accepted instruction, or start_address_i after a start.
  - target: pending redirect address.
  - stop_pend: stop requested.
- States and behaviour:
  - IDLE: no request.
  - FETCH: mem_req_o=1, mem_addr_o=pc.
  - DELIVER: instr_valid_o=1, with instr_o and instr_pc_o stable until accepted.
  - FLUSH: mem_req_o held until ack; returned data discarded.
- Memory rule: a request is never withdrawn or changed before mem_ack_i.
- Event priority, highest first: rst_i, start_i, branch_i, stop_i.
- Redirect address:
  - start_i: start_address_i. A start also sets last_pc=start_address_i and clears stop_pend.
  - branch_i: last_pc + branchloc_i, mod 2^ADDR_W. last_pc is the value before any same-cycle acceptance update.
- Redirect handling by state (start_i honoured in every state, branch_i ignored in IDLE):
  - IDLE: go to FETCH with pc=target.
  - FETCH, no ack: go to FLUSH and latch target.
  - FETCH with ack, or FLUSH with ack: drop the data, go to FETCH with pc=target.
  - FLUSH, no ack: stay in FLUSH. A new redirect overwrites target.
  - DELIVER: discard the held instruction, even if accepted this cycle. instr_valid_o drops next cycle; go to FETCH with pc=target.
- Normal flow:
  - FETCH with ack: capture instr_o=mem_data_i and instr_pc_o=pc, set pc=pc+1, go to DELIVER.
  - DELIVER with acceptance: set last_pc=instr_pc_o. Go to IDLE if stop_pend, else to FETCH.
- stop_i:
  - In IDLE: no effect.
  - In any other state: sets stop_pend, and the block goes to IDLE at the next acceptance.
  - In FLUSH: the redirect fetch still completes first.
- Width rules: pc+1 wraps 8'hFF to 8'h00. Branch addition is modular; no overflow flag.

## Timing
- Reset values:
  - State IDLE; mem_req_o, instr_valid_o and busy_o all 0.
  - mem_addr_o, instr_o, instr_pc_o, pc, last_pc, target all 0; stop_pend 0.
  - Reset mid-transaction abandons the outstanding request; the memory model must tolerate this.
- Latencies:
  - start_i at edge t: mem_req_o=1 from cycle t+1.
  - mem_ack_i at edge t: instr_valid_o=1 from cycle t+1.
  - Acceptance at edge t: next mem_req_o from t+1.
  - Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Outputs are registered and never combinationally dependent on inputs.

## Test plan
- Sequential fetch: start_i with start_address_i=8'h10, zero-wait ack, ready=1 -> instr_pc_o sequence 10,11,12,13, each valid one cycle, a request every other cycle.
- Backpressure: ready=0 for 5 cycles in DELIVER -> instr_o and instr_pc_o stable, no mem_req_o. ready=1 -> next fetch at pc+1.
- Branch with fetch in flight:
  - Setup: last_pc=8'h20, ack delayed 3 cycles.
  - Stimulus: branch_i with branchloc_i=8'hFC.
  - Required: FLUSH, returned data never presented, next request address 8'h1C.
- Wrap and negative branch:
  - Start at 8'hFE; after FF, next address 00.
  - Then branch with offset 8'h80 from last_pc=00 -> target 8'h80.
- Stop and simultaneity:
  - stop_i in FETCH -> the instruction is delivered, then IDLE after acceptance with busy_o=0.
  - start_i and branch_i in the same cycle -> start wins.
- Reset mid-FETCH: rst_i=1 while mem_req_o=1 -> all outputs at reset values next cycle; a later ack is ignored.
